vga_sync_receiver: RTL

//  Sink side of the 640x480 VGA timing link: accepts hsync/vsync/RGB from the timing generator (same pixel clock).

---
 rtl/vga_sync_receiver.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_sync_receiver : VGA timing sink; recovers counters, checks line/frame
// lengths and locks. Stats counters enabled by defining VGA_RX_STATS_EN.
// Revision: 1.0
// ============================================================================
module vga_sync_receiver #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] redin,
    input  logic [2:0] greenin,
    input  logic [1:0] bluein,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_valid,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_count,
    output logic [9:0] meas_hlen,
    output logic [9:0] meas_vlen
);

    localparam logic [10:0] C_HPIX = 11'(HPIXELS);
    localparam logic [10:0] C_VLIN = 11'(VLINES);
    localparam logic [9:0]  C_HBP  = 10'(HBP);
    localparam logic [9:0]  C_HFP  = 10'(HFP);
    localparam logic [9:0]  C_VBP  = 10'(VBP);
    localparam logic [9:0]  C_VFP  = 10'(VFP);
    localparam logic [7:0]  C_LOCK = 8'(LOCK_FRAMES);
    localparam logic [9:0]  C_CMAX = 10'h3FF;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    logic        hs_q, vs_q, vs_ls_q, fs_q;
    logic [7:0]  rgb_q;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        vs_ls_d;
    logic [10:0] w_hcnt_p1, w_vcnt_p1;
    logic        w_hfall, w_vfall, w_fs, w_err;
    logic        w_e_hlen, w_e_htmo, w_e_vlen, w_e_vtmo, w_e_vsync;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        w_win;

    // Edges are taken between the pins and the stage-1 history, so the
    // counter updated on the same edge is aligned with the registered sample.
    assign w_hfall   = !hsync && hs_q;
    assign w_vfall   = !vsync && vs_q;
    assign w_fs      = w_hfall && !vsync && vs_ls_q;
    assign w_hcnt_p1 = {1'b0, hcnt_q} + 11'd1;
    assign w_vcnt_p1 = {1'b0, vcnt_q} + 11'd1;

    assign w_e_hlen  = w_hfall && (w_hcnt_p1 != C_HPIX);
    assign w_e_htmo  = !w_hfall && (w_hcnt_p1 == C_HPIX);
    assign w_e_vlen  = w_fs && (w_vcnt_p1 != C_VLIN);
    assign w_e_vtmo  = w_hfall && !w_fs && (w_vcnt_p1 == C_VLIN);
    assign w_e_vsync = w_vfall && !w_hfall;
    assign w_err     = w_e_hlen | w_e_htmo | w_e_vlen | w_e_vtmo | w_e_vsync;

    always_comb begin
        hcnt_d  = (hcnt_q == C_CMAX) ? hcnt_q : w_hcnt_p1[9:0];
        vcnt_d  = vcnt_q;
        vs_ls_d = vs_ls_q;
        if (w_hfall) begin
            hcnt_d  = '0;
            vs_ls_d = vsync;
            if (w_fs) begin
                vcnt_d = '0;
            end else if (vcnt_q != C_CMAX) begin
                vcnt_d = w_vcnt_p1[9:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            UNLOCKED: begin
                if (w_fs) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                // An error always drops to UNLOCKED at once, so reaching a
                // frame start here implies the whole frame was clean.
                if (w_err) begin
                    state_d = UNLOCKED;
                end else if (w_fs) begin
                    good_d = good_q + 8'd1;
                    if (good_d == C_LOCK) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_err) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            vs_ls_q <= 1'b1;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            state_q <= UNLOCKED;
            good_q  <= '0;
        end else begin
            hs_q    <= hsync;
            vs_q    <= vsync;
            vs_ls_q <= vs_ls_d;
            fs_q    <= w_fs;
            rgb_q   <= {redin, greenin, bluein};
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    assign w_win = (state_q == LOCKED) &&
                   (hcnt_q >= C_HBP) && (hcnt_q < C_HFP) &&
                   (vcnt_q >= C_VBP) && (vcnt_q < C_VFP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            pixel_valid <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            x           <= hcnt_q - C_HBP;
            y           <= vcnt_q - C_VBP;
            pixel_valid <= w_win;
            red         <= w_win ? rgb_q[7:5] : 3'd0;
            green       <= w_win ? rgb_q[4:2] : 3'd0;
            blue        <= w_win ? rgb_q[1:0] : 2'd0;
            frame_start <= fs_q;
            locked      <= (state_q == LOCKED);
        end
    end

`ifdef VGA_RX_STATS_EN
    logic [7:0] errc_q;
    logic [9:0] hlen_q, vlen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errc_q <= '0;
            hlen_q <= '0;
            vlen_q <= '0;
        end else begin
            if (w_hfall) begin
                hlen_q <= w_hcnt_p1[9:0];
            end
            if (w_fs) begin
                vlen_q <= w_vcnt_p1[9:0];
            end
            if ((state_q == LOCKED) && (state_d == UNLOCKED) && (errc_q != 8'hFF)) begin
                errc_q <= errc_q + 8'd1;
            end
        end
    end

    assign err_count = errc_q;
    assign meas_hlen = hlen_q;
    assign meas_vlen = vlen_q;
`else
    assign err_count = '0;
    assign meas_hlen = '0;
    assign meas_vlen = '0;
`endif

endmodule
`default_nettype wire
